// File: rtl/trigger_word_sequencer.sv
// Sequences the parallel word for the 8:1 trigger-output serializer.
// Arbitrates timer/external requests, rotates four patterns and enforces an idle holdoff.
module trigger_word_sequencer #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      PERIOD_LOG2 = 25,
    parameter int unsigned      HOLDOFF     = 4,
    parameter int unsigned      SYNC_STAGES = 3,
    parameter logic [WIDTH-1:0] PATTERN0    = WIDTH'(8'hF0),
    parameter logic [WIDTH-1:0] PATTERN1    = WIDTH'(8'h81),
    parameter logic [WIDTH-1:0] PATTERN2    = WIDTH'(8'h88),
    parameter logic [WIDTH-1:0] PATTERN3    = WIDTH'(8'hAA)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             self_triggered_mode,
    input  logic             trigger_input,
    output logic [WIDTH-1:0] word,
    output logic             sync,
    output logic [1:0]       token,
    output logic             busy,
    output logic             pending,
    output logic [15:0]      dropped_count
);

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StHold
    } state_t;

    localparam int unsigned    HCW       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [SYNC_STAGES-1:0] trig_sync;
    logic                   trig_prev;
    logic                   ext_req;
    logic [PERIOD_LOG2-1:0] timer;
    logic                   mode_prev;
    state_t                 state;
    logic [HCW-1:0]         hold_cnt;

    logic             int_req;
    logic             req;
    logic             mode_change;
    logic             pend_eff;
    logic             can_launch;
    logic             launch;
    logic [WIDTH-1:0] next_pattern;

    always_comb begin
        int_req     = (timer == '0);
        req         = self_triggered_mode ? int_req : ext_req;
        mode_change = (self_triggered_mode != mode_prev);
        // A source switch discards whatever the old source queued.
        pend_eff    = pending & ~mode_change;
        can_launch  = (state == StIdle) || ((state == StEmit) && (HOLDOFF == 0));
        launch      = can_launch & (req | pend_eff);
        case (token)
            2'd0:    next_pattern = PATTERN0;
            2'd1:    next_pattern = PATTERN1;
            2'd2:    next_pattern = PATTERN2;
            default: next_pattern = PATTERN3;
        endcase
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            trig_sync     <= '0;
            trig_prev     <= 1'b0;
            ext_req       <= 1'b0;
            timer         <= '0;
            mode_prev     <= self_triggered_mode;
            state         <= StIdle;
            hold_cnt      <= '0;
            word          <= '0;
            sync          <= 1'b0;
            token         <= 2'd0;
            pending       <= 1'b0;
            dropped_count <= '0;
        end else begin
            trig_sync <= {trig_sync[SYNC_STAGES-2:0], trigger_input};
            trig_prev <= trig_sync[SYNC_STAGES-1];
            ext_req   <= trig_sync[SYNC_STAGES-1] & ~trig_prev;
            timer     <= timer + PERIOD_LOG2'(1);
            mode_prev <= self_triggered_mode;

            // A request arriving as the queued one is consumed re-arms the queue.
            if (launch) begin
                pending <= req & pend_eff;
            end else begin
                pending <= pend_eff | req;
                if (req && pend_eff && (dropped_count != 16'hFFFF)) begin
                    dropped_count <= dropped_count + 16'd1;
                end
            end

            if (launch) begin
                word  <= next_pattern;
                token <= token + 2'd1;
                state <= StEmit;
                if (token == 2'd0) begin
                    sync <= 1'b1;
                end else if (token == 2'd1) begin
                    sync <= 1'b0;
                end
            end else begin
                word <= '0;
                case (state)
                    StEmit: begin
                        state    <= (HOLDOFF > 0) ? StHold : StIdle;
                        hold_cnt <= HOLD_LAST;
                    end
                    StHold: begin
                        if (hold_cnt == '0) begin
                            state <= StIdle;
                        end else begin
                            hold_cnt <= hold_cnt - HCW'(1);
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
